// File: rtl/axil_cfg_sequencer.sv
// AXI4-Lite register-write sequencer: replays a stored script of writes, verified
// writes and timed waits to N_TARGETS AXI-Lite slaves over one shared master port.
module axil_cfg_sequencer #(
  parameter int N_TARGETS    = 2,
  parameter int DEPTH        = 64,
  parameter int ADDR_W       = 8,
  parameter int TIMEOUT_CYC  = 1024,
  parameter int ABORT_ON_ERR = 1,
  localparam int TGT_W   = (N_TARGETS > 1) ? $clog2(N_TARGETS) : 1,
  localparam int IDX_W   = $clog2(DEPTH),
  localparam int ENTRY_W = 34 + TGT_W + ADDR_W
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   prog_we,
  input  logic [IDX_W-1:0]       prog_addr,
  input  logic [ENTRY_W-1:0]     prog_data,
  input  logic                   start,
  input  logic                   abort,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [1:0]             err_code,
  output logic [IDX_W-1:0]       err_step,
  output logic [IDX_W:0]         step_cnt,
  output logic [ADDR_W-1:0]      m_awaddr,
  output logic [2:0]             m_awprot,
  output logic [N_TARGETS-1:0]   m_awvalid,
  input  logic [N_TARGETS-1:0]   m_awready,
  output logic [31:0]            m_wdata,
  output logic [3:0]             m_wstrb,
  output logic [N_TARGETS-1:0]   m_wvalid,
  input  logic [N_TARGETS-1:0]   m_wready,
  input  logic [2*N_TARGETS-1:0] m_bresp,
  input  logic [N_TARGETS-1:0]   m_bvalid,
  output logic [N_TARGETS-1:0]   m_bready,
  output logic [ADDR_W-1:0]      m_araddr,
  output logic [2:0]             m_arprot,
  output logic [N_TARGETS-1:0]   m_arvalid,
  input  logic [N_TARGETS-1:0]   m_arready,
  input  logic [32*N_TARGETS-1:0] m_rdata,
  input  logic [2*N_TARGETS-1:0] m_rresp,
  input  logic [N_TARGETS-1:0]   m_rvalid,
  output logic [N_TARGETS-1:0]   m_rready
);

  localparam logic [1:0] OP_WRITE   = 2'd0;
  localparam logic [1:0] OP_WVERIFY = 2'd1;
  localparam logic [1:0] OP_WAIT    = 2'd2;
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_AW_W, S_B, S_AR, S_R, S_WAIT, S_NEXT, S_FIN
  } state_t;

  state_t state, state_d;

  logic [ENTRY_W-1:0]   script_mem [DEPTH];
  logic [ENTRY_W-1:0]   rd_entry, entry_q;
  logic [IDX_W-1:0]     idx;
  logic [31:0]          wait_cnt;
  logic [TMO_W-1:0]     tmo_cnt;
  logic                 aw_pend, w_pend, abort_seen;
  logic                 inc_step, err_set;
  logic [1:0]           err_class;

  logic [1:0]           rd_op, cur_op;
  logic [TGT_W-1:0]     rd_tgt, cur_tgt;
  logic [31:0]          rd_data, cur_data;
  logic [N_TARGETS-1:0] rd_sel, cur_sel;
  logic                 aw_hs, w_hs, b_hs, ar_hs, r_hs, tmo_hit;
  logic [1:0]           bresp_sel, rresp_sel;
  logic [31:0]          rdata_sel;

  // Script RAM only accepts writes while idle; its asynchronous read feeds the FETCH decode.
  always_ff @(posedge aclk) begin
    if (prog_we && state == S_IDLE)
      script_mem[prog_addr] <= prog_data;
  end

  assign rd_entry = script_mem[idx];
  assign rd_op    = rd_entry[ENTRY_W-1 -: 2];
  assign rd_tgt   = rd_entry[32+ADDR_W +: TGT_W];
  assign rd_data  = rd_entry[31:0];
  assign cur_op   = entry_q[ENTRY_W-1 -: 2];
  assign cur_tgt  = entry_q[32+ADDR_W +: TGT_W];
  assign cur_data = entry_q[31:0];

  // An out-of-range target shifts the one-hot select to zero, which marks the entry as a no-op.
  assign rd_sel  = N_TARGETS'(1) << rd_tgt;
  assign cur_sel = N_TARGETS'(1) << cur_tgt;

  assign aw_hs   = aw_pend && |(m_awready & cur_sel);
  assign w_hs    = w_pend && |(m_wready & cur_sel);
  assign b_hs    = (state == S_B) && |(m_bvalid & cur_sel);
  assign ar_hs   = (state == S_AR) && |(m_arready & cur_sel);
  assign r_hs    = (state == S_R) && |(m_rvalid & cur_sel);
  assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

  always_comb begin
    bresp_sel = '0;
    rresp_sel = '0;
    rdata_sel = '0;
    for (int i = 0; i < N_TARGETS; i++) begin
      if (cur_tgt == TGT_W'(i)) begin
        bresp_sel = m_bresp[2*i +: 2];
        rresp_sel = m_rresp[2*i +: 2];
        rdata_sel = m_rdata[32*i +: 32];
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= S_IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d   = state;
    inc_step  = 1'b0;
    err_set   = 1'b0;
    err_class = 2'd0;
    unique case (state)
      S_IDLE: if (start) state_d = S_FETCH;
      S_FETCH: begin
        case (rd_op)
          OP_WRITE, OP_WVERIFY: state_d = (|rd_sel) ? S_AW_W : S_NEXT;
          OP_WAIT:              state_d = (rd_data == 32'd0) ? S_NEXT : S_WAIT;
          default: begin
            inc_step = 1'b1;
            state_d  = S_FIN;
          end
        endcase
      end
      S_AW_W: begin
        if ((!aw_pend || aw_hs) && (!w_pend || w_hs)) begin
          state_d = S_B;
        end else if (tmo_hit) begin
          err_set = 1'b1; err_class = 2'd3; state_d = S_FIN;
        end
      end
      S_B: begin
        if (b_hs) begin
          if (bresp_sel != 2'b00) begin
            err_set = 1'b1; err_class = 2'd1;
            state_d = (ABORT_ON_ERR != 0) ? S_FIN : S_NEXT;
          end else begin
            state_d = (cur_op == OP_WVERIFY) ? S_AR : S_NEXT;
          end
        end else if (tmo_hit) begin
          err_set = 1'b1; err_class = 2'd3; state_d = S_FIN;
        end
      end
      S_AR: begin
        if (ar_hs) begin
          state_d = S_R;
        end else if (tmo_hit) begin
          err_set = 1'b1; err_class = 2'd3; state_d = S_FIN;
        end
      end
      S_R: begin
        if (r_hs) begin
          if (rresp_sel != 2'b00) begin
            err_set = 1'b1; err_class = 2'd1;
          end else if (rdata_sel != cur_data) begin
            err_set = 1'b1; err_class = 2'd2;
          end
          state_d = (err_set && ABORT_ON_ERR != 0) ? S_FIN : S_NEXT;
        end else if (tmo_hit) begin
          err_set = 1'b1; err_class = 2'd3; state_d = S_FIN;
        end
      end
      S_WAIT: if (wait_cnt == 32'd1) state_d = S_NEXT;
      S_NEXT: begin
        inc_step = 1'b1;
        if (idx == IDX_W'(DEPTH - 1) || abort_seen || abort) state_d = S_FIN;
        else                                                 state_d = S_FETCH;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Run bookkeeping; a timeout drops the pending valids because the FSM leaves AW_W for FIN.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      entry_q    <= '0;
      idx        <= '0;
      wait_cnt   <= '0;
      tmo_cnt    <= '0;
      aw_pend    <= 1'b0;
      w_pend     <= 1'b0;
      abort_seen <= 1'b0;
      step_cnt   <= '0;
      error      <= 1'b0;
      err_code   <= 2'd0;
      err_step   <= '0;
    end else begin
      if (state_d != state)
        tmo_cnt <= '0;
      else if (tmo_cnt != TMO_W'(TIMEOUT_CYC))
        tmo_cnt <= tmo_cnt + TMO_W'(1);

      aw_pend <= (state_d == S_AW_W) && ((state == S_FETCH) || (aw_pend && !aw_hs));
      w_pend  <= (state_d == S_AW_W) && ((state == S_FETCH) || (w_pend && !w_hs));

      if (state == S_FETCH) begin
        entry_q  <= rd_entry;
        wait_cnt <= rd_data;
      end else if (state == S_WAIT) begin
        wait_cnt <= wait_cnt - 32'd1;
      end

      if (state == S_IDLE && start) begin
        idx        <= '0;
        step_cnt   <= '0;
        error      <= 1'b0;
        err_code   <= 2'd0;
        err_step   <= '0;
        abort_seen <= 1'b0;
      end else begin
        if (abort && busy) abort_seen <= 1'b1;
        if (inc_step) step_cnt <= step_cnt + (IDX_W+1)'(1);
        if (state == S_NEXT && state_d == S_FETCH) idx <= idx + IDX_W'(1);
        if (err_set && !error) begin
          error    <= 1'b1;
          err_code <= err_class;
          err_step <= idx;
        end
      end
    end
  end

  assign busy      = (state != S_IDLE) && (state != S_FIN);
  assign done      = (state == S_FIN);
  assign m_awaddr  = entry_q[32 +: ADDR_W];
  assign m_araddr  = entry_q[32 +: ADDR_W];
  assign m_wdata   = cur_data;
  assign m_wstrb   = 4'hF;
  assign m_awprot  = 3'd0;
  assign m_arprot  = 3'd0;
  assign m_awvalid = aw_pend ? cur_sel : '0;
  assign m_wvalid  = w_pend ? cur_sel : '0;
  assign m_bready  = (state == S_B) ? cur_sel : '0;
  assign m_arvalid = (state == S_AR) ? cur_sel : '0;
  assign m_rready  = (state == S_R) ? cur_sel : '0;

endmodule

// File: tb/tb_axil_cfg_sequencer.sv
// Scoreboard bench for axil_cfg_sequencer: directed scripts against two simple AXI-Lite
// slave models; expected bus writes and completion status are queued and checked by a monitor.
module tb_axil_cfg_sequencer;

  localparam int NT    = 2;
  localparam int DEPTH = 64;
  localparam int AW    = 8;
  localparam int TMO   = 1024;
  localparam int IDX_W = 6;
  localparam int EW    = 34 + 1 + AW;

  typedef struct packed {
    logic [1:0]  kind;
    logic [3:0]  tgt;
    logic [31:0] a;
    logic [31:0] d;
  } exp_t;

  logic              aclk = 1'b0;
  logic              aresetn = 1'b0;
  logic              prog_we = 1'b0;
  logic [IDX_W-1:0]  prog_addr = '0;
  logic [EW-1:0]     prog_data = '0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              busy, done, error;
  logic [1:0]        err_code;
  logic [IDX_W-1:0]  err_step;
  logic [IDX_W:0]    step_cnt;
  logic [AW-1:0]     m_awaddr, m_araddr;
  logic [2:0]        m_awprot, m_arprot;
  logic [31:0]       m_wdata;
  logic [3:0]        m_wstrb;
  logic [NT-1:0]     m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
  wire  [NT-1:0]     m_awready, m_wready, m_bvalid, m_arready, m_rvalid;
  wire  [2*NT-1:0]   m_bresp, m_rresp;
  wire  [32*NT-1:0]  m_rdata;

  logic [NT-1:0]     aw_stall = '0;
  logic [NT-1:0]     b_stall = '0;
  logic [NT-1:0]     slverr_en = '0;
  logic [7:0]        slverr_addr [NT];
  logic [31:0]       rd_xor [NT];

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  int   neg_cnt = 0, done_cnt = 0, busy_t = 0, done_t = 0;
  int   b0_t = 0, aw1_rise_t = 0, aw0_run = 0, aw1_cnt = 0;
  logic prev_busy = 1'b0, prev_aw0 = 1'b0, prev_aw1 = 1'b0;

  axil_cfg_sequencer #(
    .N_TARGETS(NT), .DEPTH(DEPTH), .ADDR_W(AW), .TIMEOUT_CYC(TMO), .ABORT_ON_ERR(0)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .start(start), .abort(abort), .busy(busy), .done(done),
    .error(error), .err_code(err_code), .err_step(err_step), .step_cnt(step_cnt),
    .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  always #5 aclk = ~aclk;

  // Slave models: zero-wait AW/W/AR, B and R one cycle after the request, optional stalls and faults.
  for (genvar g = 0; g < NT; g++) begin : g_slv
    logic        aw_got, w_got, bv, rv;
    logic [1:0]  br;
    logic [7:0]  aa;
    logic [31:0] wd, rd;
    logic        aw_hs, w_hs;
    assign aw_hs = m_awvalid[g] && m_awready[g];
    assign w_hs  = m_wvalid[g] && m_wready[g];
    always @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
        aw_got <= 1'b0; w_got <= 1'b0; bv <= 1'b0; rv <= 1'b0;
        br <= 2'b00; aa <= '0; wd <= '0; rd <= '0;
      end else begin
        if (bv && m_bready[g]) bv <= 1'b0;
        if (rv && m_rready[g]) rv <= 1'b0;
        if (aw_hs) begin aw_got <= 1'b1; aa <= m_awaddr; end
        if (w_hs)  begin w_got <= 1'b1; wd <= m_wdata; end
        if ((aw_got || aw_hs) && (w_got || w_hs) && !bv && !b_stall[g]) begin
          bv <= 1'b1;
          br <= (slverr_en[g] && (aw_hs ? m_awaddr : aa) == slverr_addr[g]) ? 2'b10 : 2'b00;
          aw_got <= 1'b0;
          w_got  <= 1'b0;
        end
        if (m_arvalid[g] && m_arready[g]) begin rv <= 1'b1; rd <= wd ^ rd_xor[g]; end
      end
    end
    assign m_awready[g]      = !aw_stall[g];
    assign m_wready[g]       = 1'b1;
    assign m_arready[g]      = 1'b1;
    assign m_bvalid[g]       = bv;
    assign m_bresp[2*g +: 2] = br;
    assign m_rvalid[g]       = rv;
    assign m_rresp[2*g +: 2] = 2'b00;
    assign m_rdata[32*g +: 32] = rd;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic popCheck(input string name, input logic [1:0] kind, input logic [3:0] tgt,
                          input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    if (exp_q.size() == 0) begin
      checkOutput({name, "_unexpected"}, 64'd1, 64'd0);
      return;
    end
    e = exp_q.pop_front();
    checkOutput({name, "_kind_tgt"}, {58'd0, kind, tgt}, {58'd0, e.kind, e.tgt});
    checkOutput({name, "_addr_data"}, {a, d}, {e.a, e.d});
  endtask

  // Monitor: compares every AW handshake and every done pulse against the queue head.
  always @(negedge aclk) begin
    neg_cnt   <= neg_cnt + 1;
    prev_busy <= busy;
    prev_aw0  <= m_awvalid[0];
    prev_aw1  <= m_awvalid[1];
    if (busy && !prev_busy) busy_t <= neg_cnt;
    if (m_bvalid[0] && m_bready[0]) b0_t <= neg_cnt;
    if (m_awvalid[1] && !prev_aw1) aw1_rise_t <= neg_cnt;
    if (m_awvalid[0]) aw0_run <= prev_aw0 ? aw0_run + 1 : 1;
    for (int i = 0; i < NT; i++) begin
      if (m_awvalid[i] && m_awready[i]) begin
        if (i == 1) aw1_cnt <= aw1_cnt + 1;
        popCheck("aw_write", 2'd0, 4'(i), 32'(m_awaddr), m_wdata);
      end
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_t   <= neg_cnt;
      popCheck("done_status", 2'd1, 4'd0, 32'd0,
               {16'd0, error, err_code, err_step, step_cnt});
    end
  end

  function automatic logic [EW-1:0] ent(input logic [1:0] op, input logic tgt,
                                        input logic [7:0] a, input logic [31:0] d);
    return {op, tgt, a, d};
  endfunction

  task automatic progEntry(input int idx, input logic [EW-1:0] e);
    @(posedge aclk); #1;
    prog_we = 1'b1; prog_addr = IDX_W'(idx); prog_data = e;
    @(posedge aclk); #1;
    prog_we = 1'b0;
  endtask

  task automatic expWrite(input logic [3:0] t, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.kind = 2'd0; e.tgt = t; e.a = a; e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic expDone(input logic er, input logic [1:0] code, input logic [5:0] stp,
                         input logic [6:0] cnt);
    exp_t e;
    e.kind = 2'd1; e.tgt = 4'd0; e.a = 32'd0; e.d = {16'd0, er, code, stp, cnt};
    exp_q.push_back(e);
  endtask

  // Pulse start, confirm busy rises one cycle later, then wait (bounded) for the done pulse.
  task automatic applyStimulus(input int budget);
    int d0;
    d0 = done_cnt;
    @(posedge aclk); #1 start = 1'b1;
    @(negedge aclk);
    checkOutput("busy_before_edge", 64'(busy), 64'd0);
    @(posedge aclk); #1 start = 1'b0;
    @(negedge aclk);
    checkOutput("busy_after_start", 64'(busy), 64'd1);
    for (int k = 0; k < budget && done_cnt == d0; k++) @(posedge aclk);
    if (done_cnt == d0) checkOutput("done_wait_expired", 64'd0, 64'd1);
    repeat (2) @(posedge aclk);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ctl"}, 64'({busy, done, error, err_code, err_step, step_cnt}), 64'd0);
    checkOutput({tag, "_valids"}, 64'({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}), 64'd0);
    checkOutput({tag, "_addr_data"}, 64'({m_awaddr, m_araddr, m_wdata}), 64'd0);
  endtask

  initial begin
    int a1;
    for (int i = 0; i < NT; i++) begin slverr_addr[i] = '0; rd_xor[i] = '0; end
    repeat (3) @(posedge aclk);
    checkAllZero("reset");
    checkOutput("wstrb", 64'(m_wstrb), 64'hF);
    @(negedge aclk) aresetn = 1'b1;

    // Two plain writes on t0, then END: exact latency and no t1 traffic.
    progEntry(0, ent(2'd0, 1'b0, 8'h04, 32'h2222_2222));
    progEntry(1, ent(2'd0, 1'b0, 8'h08, 32'h0000_0002));
    progEntry(2, ent(2'd3, 1'b0, 8'h00, 32'h0));
    expWrite(4'd0, 32'h04, 32'h2222_2222);
    expWrite(4'd0, 32'h08, 32'h0000_0002);
    expDone(1'b0, 2'd0, 6'd0, 7'd3);
    a1 = aw1_cnt;
    applyStimulus(200);
    checkOutput("latency_busy_to_done", 64'(done_t - busy_t), 64'd9);
    checkOutput("t1_idle", 64'(aw1_cnt - a1), 64'd0);

    // WAIT of 1000 cycles between a t0 write and a t1 write.
    progEntry(0, ent(2'd0, 1'b0, 8'h00, 32'h15));
    progEntry(1, ent(2'd2, 1'b0, 8'h00, 32'd1000));
    progEntry(2, ent(2'd0, 1'b1, 8'h00, 32'h29));
    progEntry(3, ent(2'd3, 1'b0, 8'h00, 32'h0));
    expWrite(4'd0, 32'h00, 32'h15);
    expWrite(4'd1, 32'h00, 32'h29);
    expDone(1'b0, 2'd0, 6'd0, 7'd4);
    applyStimulus(3000);
    checkOutput("wait_min_gap", 64'((aw1_rise_t - b0_t) >= 1001), 64'd1);
    checkOutput("wait_exact_gap", 64'(aw1_rise_t - b0_t), 64'd1005);

    // Verified write where the slave reads back a corrupted value.
    rd_xor[1] = 32'h1;
    progEntry(0, ent(2'd1, 1'b1, 8'h10, 32'h0000_0251));
    progEntry(1, ent(2'd3, 1'b0, 8'h00, 32'h0));
    expWrite(4'd1, 32'h10, 32'h0000_0251);
    expDone(1'b1, 2'd2, 6'd0, 7'd2);
    applyStimulus(200);
    rd_xor[1] = 32'h0;

    // SLVERR on entry 2 with the script continuing; entry 1 is a clean verified write.
    slverr_en[0] = 1'b1; slverr_addr[0] = 8'h28;
    progEntry(0, ent(2'd0, 1'b0, 8'h20, 32'hA0));
    progEntry(1, ent(2'd1, 1'b1, 8'h24, 32'hA1));
    progEntry(2, ent(2'd0, 1'b0, 8'h28, 32'hA2));
    progEntry(3, ent(2'd0, 1'b1, 8'h2C, 32'hA3));
    progEntry(4, ent(2'd3, 1'b0, 8'h00, 32'h0));
    expWrite(4'd0, 32'h20, 32'hA0);
    expWrite(4'd1, 32'h24, 32'hA1);
    expWrite(4'd0, 32'h28, 32'hA2);
    expWrite(4'd1, 32'h2C, 32'hA3);
    expDone(1'b1, 2'd1, 6'd2, 7'd5);
    applyStimulus(300);
    slverr_en[0] = 1'b0;

    // AWREADY stuck low on t0: timeout after TMO cycles of AWVALID.
    aw_stall[0] = 1'b1;
    progEntry(0, ent(2'd0, 1'b0, 8'h30, 32'h5));
    progEntry(1, ent(2'd3, 1'b0, 8'h00, 32'h0));
    expDone(1'b1, 2'd3, 6'd0, 7'd0);
    applyStimulus(TMO + 200);
    checkOutput("timeout_awvalid_cycles", 64'(aw0_run), 64'(TMO));
    checkOutput("timeout_awvalid_dropped", 64'(m_awvalid), 64'd0);
    aw_stall[0] = 1'b0;

    // Reset during the B phase, then rerun the retained script.
    b_stall[0] = 1'b1;
    progEntry(0, ent(2'd0, 1'b0, 8'h40, 32'h66));
    expWrite(4'd0, 32'h40, 32'h66);
    @(posedge aclk); #1 start = 1'b1;
    @(posedge aclk); #1 start = 1'b0;
    for (int k = 0; k < 50 && !m_bready[0]; k++) @(negedge aclk);
    checkOutput("b_phase_reached", 64'(m_bready[0]), 64'd1);
    #2 aresetn = 1'b0;
    #1 checkAllZero("midrun_reset");
    repeat (3) @(posedge aclk);
    #1 checkAllZero("held_reset");
    @(negedge aclk) aresetn = 1'b1;
    b_stall[0] = 1'b0;
    expWrite(4'd0, 32'h40, 32'h66);
    expDone(1'b0, 2'd0, 6'd0, 7'd2);
    applyStimulus(200);

    checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
